div_pipe: RTL and testbench
===========================

Name: div_pipe

Overview:
- Iterative radix-2 integer divider implementing the RV32M DIV/DIVU/REM/REMU instructions; forms the EXE_PIPE_DIV execution pipe.
- Consumes an ix_div_inf_t issue packet from IX and produces a div_wb_inf_t result for WB.
- WB arbitrates at fixed lowest priority (pipe ID 3), so the result is held until WB accepts it.
- One operation in flight at a time.

Parameters:
- XLEN, 32, operand/result width (package constant; not overridable per instance).
- EARLY_OUT, 1, enables 1-cycle completion for divide-by-zero and signed overflow.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset (see Behaviour)
- ix_div_valid_i  in  1  IX presents a DIV op this cycle
- ix_div_i  in  71  ix_div_inf_t {rd, rs1, rs2, div_control}
- div_ready_o  out  1  unit idle; issue accepted when valid & ready
- flush_i  in  1  pipeline flush; abort any in-flight op
- div_wb_valid_o  out  1  result pending for WB
- div_wb_o  out  37  div_wb_inf_t {rd, result}
- wb_div_ack_i  in  1  WB consumed result this cycle

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, div_ready_o=1, div_wb_valid_o=0, div_wb_o=0, counter=0.
- FSM states: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - On valid&ready: latch rd and op. Record the sign of each operand for signed ops. Take absolute values as unsigned magnitudes.
  - Init remainder=0, quotient=|rs1|, counter=31.
  - If rs2==0, or signed op with rs1=0x80000000 and rs2=0xFFFFFFFF, and EARLY_OUT=1: go to DONE with the special result. Otherwise go to CALC.
- CALC:
  - Each cycle: shift {rem,quot} left 1 and trial-subtract |rs2|.
  - If the trial is non-negative: commit it and set quotient LSB=1.
  - Decrement counter; go to FIXUP after the counter==0 iteration. This is 32 CALC cycles.
- FIXUP:
  - Negate the quotient if the signs differ (DIV).
  - Negate the remainder if the dividend was negative (REM).
  - Select quotient or remainder per div_control. Go to DONE.
- DONE:
  - div_wb_valid_o=1 and div_wb_o stable until wb_div_ack_i.
  - On ack: go to IDLE, valid=0 the same edge.
- Latency, normal op: accept edge T; div_wb_valid_o high from T+34.
- Latency, early-out: valid high from T+1.
- div_ready_o=1 only in IDLE. There is no accept in the same cycle as ack; the next issue is accepted earliest one cycle after the ack edge.
- Special results (RISC-V spec):
  - x/0: DIV/DIVU quotient=0xFFFFFFFF; REM/REMU=rs1.
  - Signed overflow: DIV=0x80000000; REM=0.
  - With EARLY_OUT=0 the iterative path must produce the identical values.
- Width rules: remainder register 33 bits for the trial subtract. Magnitudes are unsigned 32-bit; |0x80000000| = 0x80000000 unsigned.
- flush_i:
  - Highest priority. In any state, next state=IDLE and div_wb_valid_o=0.
  - A flush asserted in the same cycle as valid&ready drops the issue.
  - A flush in the same cycle as ack: treated as consumed.
- ix_div_valid_i while not ready: ignored. IX must hold the op.
- Asynchronous reset mid-operation: immediate return to reset values; no output glitch beyond the reset values.

Decomposition:
- Shared package gains:
  - div_state_e {DIV_STATE_IDLE, DIV_STATE_CALC, DIV_STATE_FIXUP, DIV_STATE_DONE}
  - DIV_NUM_ITERS=32
  - DIV_CNT_WIDTH=$clog2(DIV_NUM_ITERS)
- Reuses ix_div_inf_t, div_wb_inf_t and div_op_e.
- One natural sub-module, div_sign_fixup: combinational absolute value and result negation, used at entry and at FIXUP.

Test Plan:
- DIV 7/2, rd=5 -> after 34 cycles, valid with {rd=5, result=3}. REM on the same operands -> 1.
- DIV -7/2 -> 0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1). REM 7/-2 -> 1.
- DIVU 0xFFFFFFFF/0x10 -> 0x0FFFFFFF. REMU -> 0xF.
- DIV 0x1234/0 -> 0xFFFFFFFF at T+1. REMU 0x1234/0 -> 0x1234. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same -> 0. Repeat with EARLY_OUT=0 at T+34 with the same values.
- Hold wb_div_ack_i low 10 cycles in DONE -> valid and data stable, ready=0. Issue attempts are ignored. Ack -> ready=1 the next cycle.
- Flush at CALC cycle 15 -> valid never asserts, ready=1 the next cycle. A following DIVU 100/7 returns 14. Also: rst_n low mid-CALC -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/div_pipe_pkg.sv
// Shared types and constants for the radix-2 iterative divider pipe (EXE_PIPE_DIV).
//   div_op_e      : RV32M divide opcode (low two bits of funct3)
//   ix_div_inf_t  : issue packet from IX  {rd, rs1, rs2, div_control}  (71 bits)
//   div_wb_inf_t  : result packet to WB   {rd, result}                 (37 bits)
//   div_state_e   : divider control FSM states
package div_pipe_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned DIV_NUM_ITERS = 32;
    localparam int unsigned DIV_CNT_WIDTH = $clog2(DIV_NUM_ITERS);

    localparam logic [XLEN-1:0] DIV_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        div_op_e         div_control;
    } ix_div_inf_t;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] result;
    } div_wb_inf_t;

    typedef enum logic [1:0] {
        DIV_STATE_IDLE,
        DIV_STATE_CALC,
        DIV_STATE_FIXUP,
        DIV_STATE_DONE
    } div_state_e;

    function automatic logic div_is_signed(div_op_e op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    function automatic logic div_is_rem(div_op_e op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

endpackage

// File: rtl/div_pipe_if.sv
// Issue / writeback bundle of the divider pipe.
//   ix_div_valid_i, ix_div_i : issue from IX (handshake with div_ready_o)
//   flush_i                  : abort any in-flight op
//   div_wb_valid_o, div_wb_o : result held for WB until wb_div_ack_i
// Modports: master = IX/WB side, slave = divider side.
interface div_pipe_if;
    import div_pipe_pkg::*;

    logic        ix_div_valid_i;
    ix_div_inf_t ix_div_i;
    logic        div_ready_o;
    logic        flush_i;
    logic        div_wb_valid_o;
    div_wb_inf_t div_wb_o;
    logic        wb_div_ack_i;

    modport master (
        output ix_div_valid_i, ix_div_i, flush_i, wb_div_ack_i,
        input  div_ready_o, div_wb_valid_o, div_wb_o
    );

    modport slave (
        input  ix_div_valid_i, ix_div_i, flush_i, wb_div_ack_i,
        output div_ready_o, div_wb_valid_o, div_wb_o
    );

endinterface

// File: rtl/div_sign_fixup.sv
// Combinational conditional two's-complement negation.
// Used as absolute value on entry (i_negate = operand sign) and as
// result sign correction in FIXUP.
//   i_value  : XLEN-bit input
//   i_negate : 1 -> output -i_value, 0 -> pass through
//   o_value  : XLEN-bit result
module div_sign_fixup
    import div_pipe_pkg::*;
(
    input  logic [XLEN-1:0] i_value,
    input  logic            i_negate,
    output logic [XLEN-1:0] o_value
);

    // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude.
    assign o_value = i_negate ? (~i_value + 1'b1) : i_value;

endmodule

// File: rtl/div_pipe.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One op in flight; the result is held on the bus until WB acknowledges it.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : div_pipe_if.slave (issue, flush, writeback handshake)
// EARLY_OUT = 1 finishes divide-by-zero and signed overflow in one cycle;
// with EARLY_OUT = 0 the iterative path yields the same values.
module div_pipe
    import div_pipe_pkg::*;
#(
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    div_pipe_if.slave  bus
);

    div_state_e             r_state;
    div_state_e             w_state_next;
    logic [XLEN:0]          r_rem;       // 33 bits to hold the shifted partial remainder
    logic [XLEN-1:0]        r_quot;
    logic [XLEN-1:0]        r_divisor;
    logic [DIV_CNT_WIDTH-1:0] r_cnt;
    logic [4:0]             r_rd;
    logic                   r_is_rem;
    logic                   r_neg_q;
    logic                   r_neg_r;
    div_wb_inf_t            r_wb;

    logic                   w_is_signed;
    logic                   w_rs1_neg;
    logic                   w_rs2_neg;
    logic                   w_div_by_zero;
    logic                   w_overflow;
    logic                   w_special;
    logic                   w_accept;
    logic [XLEN-1:0]        w_special_result;
    logic [XLEN-1:0]        w_abs_rs1;
    logic [XLEN-1:0]        w_abs_rs2;
    logic [XLEN+1:0]        w_trial;
    logic                   w_trial_ok;
    logic [XLEN-1:0]        w_quot_fix;
    logic [XLEN-1:0]        w_rem_fix;

    // Entry decode
    assign w_is_signed   = div_is_signed(bus.ix_div_i.div_control);
    assign w_rs1_neg     = w_is_signed && bus.ix_div_i.rs1[XLEN-1];
    assign w_rs2_neg     = w_is_signed && bus.ix_div_i.rs2[XLEN-1];
    assign w_div_by_zero = (bus.ix_div_i.rs2 == '0);
    assign w_overflow    = w_is_signed && (bus.ix_div_i.rs1 == DIV_INT_MIN)
                           && (bus.ix_div_i.rs2 == '1);
    assign w_special     = EARLY_OUT && (w_div_by_zero || w_overflow);
    assign w_accept      = bus.ix_div_valid_i && (r_state == DIV_STATE_IDLE) && !bus.flush_i;

    assign w_special_result = w_div_by_zero
        ? (div_is_rem(bus.ix_div_i.div_control) ? bus.ix_div_i.rs1 : '1)
        : (div_is_rem(bus.ix_div_i.div_control) ? '0 : DIV_INT_MIN);

    div_sign_fixup u_abs_rs1 (
        .i_value  (bus.ix_div_i.rs1),
        .i_negate (w_rs1_neg),
        .o_value  (w_abs_rs1)
    );

    div_sign_fixup u_abs_rs2 (
        .i_value  (bus.ix_div_i.rs2),
        .i_negate (w_rs2_neg),
        .o_value  (w_abs_rs2)
    );

    div_sign_fixup u_fix_quot (
        .i_value  (r_quot),
        .i_negate (r_neg_q),
        .o_value  (w_quot_fix)
    );

    div_sign_fixup u_fix_rem (
        .i_value  (r_rem[XLEN-1:0]),
        .i_negate (r_neg_r),
        .o_value  (w_rem_fix)
    );

    // Shift {rem, quot} left by one and trial-subtract the divisor; bit XLEN+1 is the sign.
    assign w_trial    = {r_rem, r_quot[XLEN-1]} - {2'b00, r_divisor};
    assign w_trial_ok = !w_trial[XLEN+1];

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            DIV_STATE_IDLE: begin
                if (bus.ix_div_valid_i) begin
                    w_state_next = w_special ? DIV_STATE_DONE : DIV_STATE_CALC;
                end
            end
            DIV_STATE_CALC: begin
                if (r_cnt == '0) begin
                    w_state_next = DIV_STATE_FIXUP;
                end
            end
            DIV_STATE_FIXUP: w_state_next = DIV_STATE_DONE;
            DIV_STATE_DONE: begin
                if (bus.wb_div_ack_i) begin
                    w_state_next = DIV_STATE_IDLE;
                end
            end
            default: w_state_next = DIV_STATE_IDLE;
        endcase
        if (bus.flush_i) begin
            w_state_next = DIV_STATE_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= DIV_STATE_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
            r_rd      <= '0;
            r_is_rem  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_wb      <= '0;
        end else if (!bus.flush_i) begin
            unique case (r_state)
                DIV_STATE_IDLE: begin
                    if (w_accept) begin
                        r_rd      <= bus.ix_div_i.rd;
                        r_is_rem  <= div_is_rem(bus.ix_div_i.div_control);
                        r_rem     <= '0;
                        r_quot    <= w_abs_rs1;
                        r_divisor <= w_abs_rs2;
                        r_cnt     <= DIV_CNT_WIDTH'(DIV_NUM_ITERS - 1);
                        // x/0 must keep quotient all-ones regardless of dividend sign.
                        r_neg_q   <= (w_rs1_neg ^ w_rs2_neg) && !w_div_by_zero;
                        r_neg_r   <= w_rs1_neg;
                        if (w_special) begin
                            r_wb <= '{rd: bus.ix_div_i.rd, result: w_special_result};
                        end
                    end
                end
                DIV_STATE_CALC: begin
                    r_rem  <= w_trial_ok ? w_trial[XLEN:0] : {r_rem[XLEN-1:0], r_quot[XLEN-1]};
                    r_quot <= {r_quot[XLEN-2:0], w_trial_ok};
                    r_cnt  <= r_cnt - 1'b1;
                end
                DIV_STATE_FIXUP: begin
                    r_wb <= '{rd: r_rd, result: (r_is_rem ? w_rem_fix : w_quot_fix)};
                end
                DIV_STATE_DONE: ;
                default: ;
            endcase
        end
    end

    assign bus.div_ready_o    = (r_state == DIV_STATE_IDLE);
    assign bus.div_wb_valid_o = (r_state == DIV_STATE_DONE);
    assign bus.div_wb_o       = r_wb;

endmodule

// File: tb/tb_div_pipe.sv
// Scoreboard bench for div_pipe: one instance with EARLY_OUT=1, one with EARLY_OUT=0,
// both fed the same directed ops. Stimulus pushes expected {rd, result, latency};
// a monitor per instance pops and compares when the result appears and drives ack.
module tb_div_pipe;
    import div_pipe_pkg::*;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] result;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic        drv_valid = 1'b0;
    ix_div_inf_t drv_ix = '0;
    logic        drv_flush = 1'b0;
    logic        ack [2] = '{default: 1'b0};
    int          hold_req = 0;

    exp_t q_e[$];
    exp_t q_n[$];

    div_pipe_if if_e ();
    div_pipe_if if_n ();

    assign if_e.ix_div_valid_i = drv_valid;
    assign if_e.ix_div_i       = drv_ix;
    assign if_e.flush_i        = drv_flush;
    assign if_e.wb_div_ack_i   = ack[0];
    assign if_n.ix_div_valid_i = drv_valid;
    assign if_n.ix_div_i       = drv_ix;
    assign if_n.flush_i        = drv_flush;
    assign if_n.wb_div_ack_i   = ack[1];

    div_pipe #(.EARLY_OUT(1'b1)) u_dut_e (.clk(clk), .rst_n(rst_n), .bus(if_e));
    div_pipe #(.EARLY_OUT(1'b0)) u_dut_n (.clk(clk), .rst_n(rst_n), .bus(if_n));

    logic        m_valid [2];
    logic        m_ready [2];
    div_wb_inf_t m_wb    [2];
    assign m_valid[0] = if_e.div_wb_valid_o;
    assign m_valid[1] = if_n.div_wb_valid_o;
    assign m_ready[0] = if_e.div_ready_o;
    assign m_ready[1] = if_n.div_ready_o;
    assign m_wb[0]    = if_e.div_wb_o;
    assign m_wb[1]    = if_n.div_wb_o;

    bit          seen [2] = '{default: 1'b0};
    int          hold [2] = '{default: 0};
    div_wb_inf_t cap  [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic mon_step(input int d);
        exp_t  e;
        string tag;
        int    qsz;
        tag = (d == 0) ? "eo1" : "eo0";
        if (ack[d]) begin
            ack[d]  = 1'b0;
            seen[d] = 1'b0;
            check({tag, " valid after ack"}, 64'(m_valid[d]), 64'd0);
            check({tag, " ready after ack"}, 64'(m_ready[d]), 64'd1);
        end else if (m_valid[d]) begin
            if (!seen[d]) begin
                seen[d] = 1'b1;
                qsz = (d == 0) ? q_e.size() : q_n.size();
                if (qsz == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL %s unexpected result: got 0x%0h, expected none", tag,
                             m_wb[d].result);
                    ack[d] = 1'b1;
                end else begin
                    e = (d == 0) ? q_e.pop_front() : q_n.pop_front();
                    check({tag, " ", e.name, " rd"}, 64'(m_wb[d].rd), 64'(e.rd));
                    check({tag, " ", e.name, " result"}, 64'(m_wb[d].result), 64'(e.result));
                    check({tag, " ", e.name, " latency"}, 64'(cyc - e.acc + 1), 64'(e.lat));
                    cap[d]  = m_wb[d];
                    hold[d] = hold_req;
                    if (hold[d] == 0) ack[d] = 1'b1;
                end
            end else begin
                check({tag, " held data"}, 64'(m_wb[d]), 64'(cap[d]));
                check({tag, " ready in done"}, 64'(m_ready[d]), 64'd0);
                hold[d]--;
                if (hold[d] <= 0) ack[d] = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) mon_step(d);
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(m_ready[0] && m_ready[1] && q_e.size() == 0 && q_n.size() == 0
                 && !ack[0] && !ack[1])) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL wait_idle: got busy, expected idle within 200 cycles");
                q_e.delete();
                q_n.delete();
                break;
            end
        end
    endtask

    task automatic issue(input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] res, input bit sp,
                         input string name, input bit push);
        exp_t e;
        wait_idle();
        drv_ix    = '{rd: rd, rs1: a, rs2: b, div_control: op};
        drv_valid = 1'b1;
        if (push) begin
            e.rd     = rd;
            e.result = res;
            e.acc    = cyc + 1;
            e.name   = name;
            e.lat    = sp ? 1 : 34;
            q_e.push_back(e);
            e.lat    = 34;
            q_n.push_back(e);
        end
        @(negedge clk);
        drv_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " eo1 ready"}, 64'(m_ready[0]), 64'd1);
        check({name, " eo1 valid"}, 64'(m_valid[0]), 64'd0);
        check({name, " eo1 data"},  64'(m_wb[0]), 64'd0);
        check({name, " eo0 ready"}, 64'(m_ready[1]), 64'd1);
        check({name, " eo0 valid"}, 64'(m_valid[1]), 64'd0);
        check({name, " eo0 data"},  64'(m_wb[1]), 64'd0);
    endtask

    initial begin
        int n;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        issue(DIV_OP_DIV,  32'd7,          32'd2,          5'd5,  32'd3,          0, "div 7/2", 1);
        issue(DIV_OP_REM,  32'd7,          32'd2,          5'd5,  32'd1,          0, "rem 7/2", 1);
        issue(DIV_OP_DIV,  32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFD,  0, "div -7/2", 1);
        issue(DIV_OP_REM,  32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFF,  0, "rem -7/2", 1);
        issue(DIV_OP_REM,  32'd7,          32'hFFFF_FFFE,  5'd8,  32'd1,          0, "rem 7/-2", 1);
        issue(DIV_OP_DIVU, 32'hFFFF_FFFF,  32'h10,         5'd9,  32'h0FFF_FFFF,  0, "divu", 1);
        issue(DIV_OP_REMU, 32'hFFFF_FFFF,  32'h10,         5'd10, 32'hF,          0, "remu", 1);
        issue(DIV_OP_DIV,  32'h1234,       32'd0,          5'd11, 32'hFFFF_FFFF,  1, "div x/0", 1);
        issue(DIV_OP_REMU, 32'h1234,       32'd0,          5'd12, 32'h1234,       1, "remu x/0", 1);
        issue(DIV_OP_DIV,  32'hFFFF_FFF9,  32'd0,          5'd13, 32'hFFFF_FFFF,  1, "div -7/0", 1);
        issue(DIV_OP_REM,  32'hFFFF_FFF9,  32'd0,          5'd14, 32'hFFFF_FFF9,  1, "rem -7/0", 1);
        issue(DIV_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd15, 32'h8000_0000,  1, "div ovf", 1);
        issue(DIV_OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd16, 32'd0,          1, "rem ovf", 1);
        issue(DIV_OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  5'd17, 32'd0,          0, "divu big", 1);
        issue(DIV_OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  5'd18, 32'h8000_0000,  0, "remu big", 1);

        // Result held without ack; issue attempts meanwhile must be ignored.
        hold_req = 10;
        issue(DIV_OP_DIVU, 32'd1000, 32'd10, 5'd19, 32'd100, 0, "divu hold", 1);
        n = 0;
        while (!m_valid[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL hold wait: got no valid, expected valid within 100 cycles");
        end
        drv_ix    = '{rd: 5'd20, rs1: 32'd9, rs2: 32'd3, div_control: DIV_OP_DIV};
        drv_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("ready eo1 during hold", 64'(m_ready[0]), 64'd0);
            check("ready eo0 during hold", 64'(m_ready[1]), 64'd0);
        end
        drv_valid = 1'b0;
        hold_req  = 0;

        // Flush together with valid&ready drops the issue.
        wait_idle();
        drv_ix    = '{rd: 5'd21, rs1: 32'd50, rs2: 32'd5, div_control: DIV_OP_DIVU};
        drv_valid = 1'b1;
        drv_flush = 1'b1;
        @(negedge clk);
        drv_valid = 1'b0;
        drv_flush = 1'b0;
        check("ready eo1 after flushed issue", 64'(m_ready[0]), 64'd1);
        check("ready eo0 after flushed issue", 64'(m_ready[1]), 64'd1);

        // Flush at CALC cycle 15.
        issue(DIV_OP_DIV, 32'd1000, 32'd3, 5'd22, 32'd0, 0, "flushed", 0);
        repeat (14) @(negedge clk);
        drv_flush = 1'b1;
        @(negedge clk);
        drv_flush = 1'b0;
        check("ready eo1 after flush", 64'(m_ready[0]), 64'd1);
        check("ready eo0 after flush", 64'(m_ready[1]), 64'd1);
        check("valid eo1 after flush", 64'(m_valid[0]), 64'd0);
        check("valid eo0 after flush", 64'(m_valid[1]), 64'd0);
        issue(DIV_OP_DIVU, 32'd100, 32'd7, 5'd23, 32'd14, 0, "divu 100/7", 1);

        // Asynchronous reset mid-CALC.
        issue(DIV_OP_DIV, 32'd7, 32'd2, 5'd24, 32'd3, 0, "reset victim", 0);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        issue(DIV_OP_DIV, 32'd7, 32'd2, 5'd25, 32'd3, 0, "div after reset", 1);

        wait_idle();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout, expected completion before 200000 time units");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
